lsu_mem_access: RTL and testbench

- Multi-cycle load/store unit that consumes the memory-control outputs of the instruction decoder: MemOp, MemWr and MemtoReg (as the read request), plus the ALU-computed address and the rs2 store data.
- Performs one request/acknowledge transaction on a 32-bit word-addressed data bus.
- Generates byte enables, replicates store data, and sign- or zero-extends load data.
- Stalls the core via `busy` until `done` pulses.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_mem_access.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_access.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op codes, FSM encoding,
// byte-enable base patterns and access-size helpers.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] MEMOP_W  = 3'b000;
    localparam logic [2:0] MEMOP_B  = 3'b001;
    localparam logic [2:0] MEMOP_H  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b101;
    localparam logic [2:0] MEMOP_HU = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // Access size of a mem_op code; unassigned codes behave as word
    function automatic size_e op_size(input logic [2:0] op);
        case (op)
            MEMOP_B, MEMOP_BU: return SZ_BYTE;
            MEMOP_H, MEMOP_HU: return SZ_HALF;
            MEMOP_W:           return SZ_WORD;
            default:           return SZ_WORD;
        endcase
    endfunction

    // True when the access is not naturally aligned for its size
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] ofs);
        case (op_size(op))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return ofs[0];
            default: return (ofs != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: byte enables, store-data
// replication and load-data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [1:0]        ofs,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] shifted;
    logic              sext;

    // Select lanes by size and offset; loads are shifted down then extended
    always_comb begin
        shifted = rdata >> {ofs, 3'b000};
        sext    = ~op[2];
        be_c    = BE_WORD;
        wdata_c = wdata;
        rdata_c = shifted;
        case (op_size(op))
            SZ_BYTE: begin
                be_c    = BE_BYTE << ofs;
                wdata_c = {4{wdata[7:0]}};
                rdata_c = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_c    = BE_HALF << {ofs[1], 1'b0};
                wdata_c = {2{wdata[15:0]}};
                rdata_c = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Multi-cycle load/store unit: one req/ack transaction per accepted request,
// misaligned accesses complete without touching the bus.
// Optional build macro LSU_TIMEOUT_EN adds a REQ-state abort counter.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mem_op,
    input  logic              mem_wr,
    input  logic              mem_rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              timeout,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        ofs_q, ofs_d;
    logic              busy_d, done_d, misalign_d, bus_req_d, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [3:0]        bus_be_d;
    logic [31:0]       bus_wdata_d, rdata_d;

    logic [2:0]        align_op;
    logic [1:0]        align_ofs;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c, rdata_c;
    logic              accept_c;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_d;
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT;
    assign timeout = 1'b0;
`endif

    assign accept_c = start & (mem_wr | mem_rd);

    // Shared aligner sees the incoming request in IDLE, the latched one afterwards
    assign align_op  = (state_q == ST_IDLE) ? mem_op     : op_q;
    assign align_ofs = (state_q == ST_IDLE) ? addr[1:0]  : ofs_q;

    lsu_align u_align (
        .op      (align_op),
        .ofs     (align_ofs),
        .wdata   (wdata),
        .rdata   (bus_rdata),
        .be_c    (be_c),
        .wdata_c (wdata_c),
        .rdata_c (rdata_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ofs_d       = ofs_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_req_d   = 1'b0;
        bus_we_d    = bus_we;
        bus_addr_d  = bus_addr;
        bus_be_d    = bus_be;
        bus_wdata_d = bus_wdata;
        rdata_d     = rdata;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d  = mem_op;
                    ofs_d = addr[1:0];
                    if (is_misaligned(mem_op, addr[1:0])) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_wr;
                        bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        bus_be_d    = be_c;
                        bus_wdata_d = wdata_c;
`ifdef LSU_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            ST_REQ: begin
                bus_req_d = 1'b1;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                    if (!bus_we) begin
                        rdata_d = rdata_c;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                    if (!bus_we) begin
                        rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            ofs_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ofs_q     <= ofs_d;
            busy      <= busy_d;
            done      <= done_d;
            misalign  <= misalign_d;
            bus_req   <= bus_req_d;
            bus_we    <= bus_we_d;
            bus_addr  <= bus_addr_d;
            bus_be    <= bus_be_d;
            bus_wdata <= bus_wdata_d;
            rdata     <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout   <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Self-checking bench for lsu_mem_access: directed cases plus randomized
// transactions compared against a byte-level behavioural model.
module tb_lsu_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mem_op = '0;
    logic        mem_wr = 1'b0;
    logic        mem_rd = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misalign, timeout;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int passes = 0;
    logic [31:0] model_rdata = '0;

    lsu_mem_access #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_op(mem_op), .mem_wr(mem_wr),
        .mem_rd(mem_rd), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .misalign(misalign), .timeout(timeout), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    function automatic int m_size(input logic [2:0] op);
        if (op == 3'b001 || op == 3'b101) return 1;
        if (op == 3'b010 || op == 3'b110) return 2;
        return 4;
    endfunction

    function automatic logic m_mis(input logic [2:0] op, input logic [31:0] a);
        return (a % m_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
        logic [3:0] be = '0;
        int sz = m_size(op);
        int base = int'(a % 4) / sz * sz;
        for (int i = 0; i < sz; i++) be[base + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int sz = m_size(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        int sz = m_size(op);
        logic [31:0] v = w >> (8 * (a % 4));
        logic [31:0] mask;
        if (sz == 4) return v;
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = v & mask;
        if (op[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- transaction driver ----------------
    logic [3:0]  o_be;
    logic [31:0] o_wdata, o_addr, o_rdata;
    logic        o_we, o_mis, o_to, o_stable, o_busy, o_seen, o_post;
    int          o_req, o_lat;

    task automatic access(input logic [2:0] op, input logic wr, input logic rd,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input int waits);
        int cyc;
        o_be = '0; o_wdata = '0; o_addr = '0; o_rdata = '0; o_we = 1'b0;
        o_mis = 1'b0; o_to = 1'b0; o_stable = 1'b1; o_busy = 1'b1; o_seen = 1'b0;
        o_req = 0; o_lat = 0;
        @(negedge clk);
        start = 1'b1; mem_op = op; mem_wr = wr; mem_rd = rd; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0; mem_op = 3'($urandom); addr = $urandom; wdata = $urandom;
        mem_wr = 1'($urandom); mem_rd = 1'($urandom);
        cyc = 1;
        while (!o_seen && cyc <= 60) begin
            @(negedge clk);
            if (!busy) o_busy = 1'b0;
            if (bus_req) begin
                if (o_req == 0) begin
                    o_be = bus_be; o_wdata = bus_wdata; o_addr = bus_addr; o_we = bus_we;
                end else if (bus_be !== o_be || bus_wdata !== o_wdata ||
                             bus_addr !== o_addr || bus_we !== o_we) begin
                    o_stable = 1'b0;
                end
                if (o_req == waits) begin
                    bus_ack = 1'b1; bus_rdata = word;
                end
                o_req++;
            end
            if (done) begin
                o_seen = 1'b1; o_lat = cyc; o_mis = misalign; o_to = timeout; o_rdata = rdata;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = $urandom;
            start = o_seen ? 1'b0 : 1'($urandom);
            cyc++;
        end
        start = 1'b0;
        @(negedge clk);
        o_post = !done && !busy && !misalign && !bus_req;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        #3;
        checks++;
        if ({busy, done, misalign, timeout, bus_req, bus_we} !== 6'b0 ||
            bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0 || rdata !== 32'h0)
            $display("FAIL reset_values got busy=%b done=%b req=%b be=%h addr=%h wd=%h rd=%h exp all 0",
                     busy, done, bus_req, bus_be, bus_addr, bus_wdata, rdata);
        else passes++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_word;
        access(3'b000, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        checks++;
        if (o_be !== 4'b1111 || o_wdata !== 32'hDEADBEEF || o_we !== 1'b1 || o_addr !== 32'h100)
            $display("FAIL sw_lanes got be=%b wd=%h we=%b addr=%h exp be=1111 wd=deadbeef we=1 addr=100",
                     o_be, o_wdata, o_we, o_addr);
        else passes++;
        checks++;
        if (o_lat !== 2 || o_req !== 1)
            $display("FAIL sw_latency got done_cycle=%0d req_cycles=%0d exp 2 1", o_lat, o_req);
        else passes++;
        checks++;
        if (rdata !== model_rdata || o_post !== 1'b1)
            $display("FAIL sw_rdata_hold got rdata=%h post=%b exp %h 1", rdata, o_post, model_rdata);
        else passes++;
    endtask

    task automatic test_store_byte;
        access(3'b001, 1'b1, 1'b1, 32'h103, 32'h000000A5, 32'h0, 1);
        checks++;
        if (o_addr !== 32'h100 || o_be !== 4'b1000 || o_wdata !== 32'hA5A5A5A5 || o_we !== 1'b1)
            $display("FAIL sb_lanes got addr=%h be=%b wd=%h we=%b exp 100 1000 a5a5a5a5 1",
                     o_addr, o_be, o_wdata, o_we);
        else passes++;
        checks++;
        if (o_lat !== 3 || o_stable !== 1'b1)
            $display("FAIL sb_latency got done_cycle=%0d stable=%b exp 3 1", o_lat, o_stable);
        else passes++;
    endtask

    task automatic test_load_byte;
        access(3'b001, 1'b0, 1'b1, 32'h101, 32'h0, 32'h12348056, 3);
        checks++;
        if (o_rdata !== 32'hFFFFFF80 || o_be !== 4'b0010 || o_we !== 1'b0)
            $display("FAIL lb_result got rdata=%h be=%b we=%b exp ffffff80 0010 0", o_rdata, o_be, o_we);
        else passes++;
        checks++;
        if (o_req !== 4 || o_busy !== 1'b1 || o_stable !== 1'b1 || o_lat !== 5)
            $display("FAIL lb_wait got req_cycles=%0d busy=%b stable=%b done_cycle=%0d exp 4 1 1 5",
                     o_req, o_busy, o_stable, o_lat);
        else passes++;
        access(3'b101, 1'b0, 1'b1, 32'h101, 32'h0, 32'h12348056, 3);
        model_rdata = 32'h00000080;
        checks++;
        if (o_rdata !== 32'h00000080)
            $display("FAIL lbu_result got %h exp 00000080", o_rdata);
        else passes++;
    endtask

    task automatic test_load_half;
        access(3'b010, 1'b0, 1'b1, 32'h102, 32'h0, 32'h80010000, 0);
        checks++;
        if (o_rdata !== 32'hFFFF8001 || o_be !== 4'b1100)
            $display("FAIL lh_result got rdata=%h be=%b exp ffff8001 1100", o_rdata, o_be);
        else passes++;
        access(3'b110, 1'b0, 1'b1, 32'h102, 32'h0, 32'h80010000, 2);
        model_rdata = 32'h00008001;
        checks++;
        if (o_rdata !== 32'h00008001)
            $display("FAIL lhu_result got %h exp 00008001", o_rdata);
        else passes++;
    endtask

    task automatic test_misalign;
        access(3'b000, 1'b0, 1'b1, 32'h102, 32'h0, 32'h0, 0);
        checks++;
        if (o_req !== 0 || o_lat !== 1 || o_mis !== 1'b1 || o_to !== 1'b0)
            $display("FAIL lw_misalign got req_cycles=%0d done_cycle=%0d mis=%b to=%b exp 0 1 1 0",
                     o_req, o_lat, o_mis, o_to);
        else passes++;
        checks++;
        if (o_rdata !== model_rdata || o_post !== 1'b1)
            $display("FAIL misalign_clear got rdata=%h post=%b exp %h 1", o_rdata, o_post, model_rdata);
        else passes++;
    endtask

    task automatic test_ignored_start;
        int seen = 0;
        @(negedge clk);
        start = 1'b1; mem_wr = 1'b0; mem_rd = 1'b0; mem_op = 3'b000; addr = 32'h200;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy || bus_req || done) seen++;
        end
        checks++;
        if (seen !== 0)
            $display("FAIL idle_no_dir got active_cycles=%0d exp 0", seen);
        else passes++;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        @(negedge clk);
        start = 1'b1; mem_op = 3'b000; mem_wr = 1'b0; mem_rd = 1'b1; addr = 32'h40;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || busy !== 1'b1)
            $display("FAIL mid_pre_req got req=%b busy=%b exp 1 1", bus_req, busy);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_reset_drop got req=%b busy=%b exp 0 0", bus_req, busy);
        else passes++;
        model_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0 || rdata !== 32'h0)
            $display("FAIL mid_reset_nodone got done_cycles=%0d rdata=%h exp 0 0", seen, rdata);
        else passes++;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout;
        access(3'b000, 1'b0, 1'b1, 32'h300, 32'h0, 32'h0, 1000);
        model_rdata = '0;
        checks++;
        if (o_seen !== 1'b1 || o_to !== 1'b1 || o_rdata !== 32'h0 || o_mis !== 1'b0)
            $display("FAIL timeout_abort got done=%b to=%b rdata=%h mis=%b exp 1 1 0 0",
                     o_seen, o_to, o_rdata, o_mis);
        else passes++;
    endtask
`endif

    task automatic test_random;
        logic [2:0]  op;
        logic        wr, rd, mis;
        logic [31:0] a, wd, word;
        int          waits;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom); a = $urandom; wd = $urandom; word = $urandom;
            wr = 1'($urandom); rd = wr ? 1'($urandom) : 1'b1;
            waits = int'($urandom_range(0, 3));
            mis = m_mis(op, a);
            access(op, wr, rd, a, wd, word, waits);
            if (!mis && !wr) model_rdata = m_load(op, a, word);
            checks++;
            if (o_seen !== 1'b1 || o_mis !== mis || o_to !== 1'b0 || o_post !== 1'b1 || o_busy !== 1'b1)
                $display("FAIL rnd_done[%0d] got seen=%b mis=%b to=%b post=%b busy=%b exp 1 %b 0 1 1",
                         n, o_seen, o_mis, o_to, o_post, o_busy, mis);
            else passes++;
            checks++;
            if (o_lat !== (mis ? 1 : 2 + waits) || o_req !== (mis ? 0 : waits + 1))
                $display("FAIL rnd_timing[%0d] got done_cycle=%0d req_cycles=%0d exp %0d %0d",
                         n, o_lat, o_req, mis ? 1 : 2 + waits, mis ? 0 : waits + 1);
            else passes++;
            if (!mis) begin
                checks++;
                if (o_be !== m_be(op, a) || o_addr !== {a[31:2], 2'b00} || o_we !== wr || o_stable !== 1'b1 ||
                    (wr && o_wdata !== m_wdata(op, wd)))
                    $display("FAIL rnd_bus[%0d] op=%b a=%h got be=%b addr=%h we=%b wd=%h exp be=%b addr=%h we=%b wd=%h",
                             n, op, a, o_be, o_addr, o_we, o_wdata, m_be(op, a), {a[31:2], 2'b00}, wr, m_wdata(op, wd));
                else passes++;
            end
            checks++;
            if (o_rdata !== model_rdata)
                $display("FAIL rnd_rdata[%0d] op=%b a=%h got %h exp %h", n, op, a, o_rdata, model_rdata);
            else passes++;
        end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_store_byte;
        test_load_byte;
        test_load_half;
        test_misalign;
        test_ignored_start;
        test_random;
        test_reset_mid;
`ifdef LSU_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
